// File: rtl/program_rom_pkg.sv
// Shared types and constants for the 4-bit computer's instruction store:
// word layout, opcode encodings and the built-in default program.
package program_rom_pkg;

  localparam int ROM_ADDR_W = 4;
  localparam int ROM_DATA_W = 8;
  localparam int ROM_DEPTH  = 1 << ROM_ADDR_W;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_OUT = 4'h4,
    OP_JMP = 4'h5,
    OP_JZ  = 4'h6,
    OP_HLT = 4'hF
  } opcode_e;

  typedef struct packed {
    opcode_e    opcode;
    logic [3:0] operand;
  } instr_t;

  typedef logic [ROM_DEPTH-1:0][ROM_DATA_W-1:0] image_t;

  function automatic logic [ROM_DATA_W-1:0] mk_instr(opcode_e op, logic [3:0] operand);
    instr_t i;
    i.opcode  = op;
    i.operand = operand;
    return i;
  endfunction

  // Count up from 1 via the accumulator forever; slot 15 parks a HLT.
  function automatic image_t default_image();
    image_t img;
    img     = '0;
    img[0]  = mk_instr(OP_LDA, 4'd0);
    img[1]  = mk_instr(OP_ADD, 4'd1);
    img[2]  = mk_instr(OP_OUT, 4'd0);
    img[3]  = mk_instr(OP_JMP, 4'd1);
    img[15] = mk_instr(OP_HLT, 4'd0);
    return img;
  endfunction

  localparam image_t DEFAULT_IMAGE = default_image();

endpackage

// File: rtl/program_rom_if.sv
// Fetch and load-port bundle between the CPU/loader (master) and the ROM (slave).
interface program_rom_if
  import program_rom_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] prog;
  logic [DATA_W-1:0] prog_q;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              modified;

  modport master (
    output addr, wr_en, wr_addr, wr_data,
    input  prog, prog_q, modified
  );

  modport slave (
    input  addr, wr_en, wr_addr, wr_data,
    output prog, prog_q, modified
  );
endinterface

// File: rtl/program_rom.sv
// 16x8 writable instruction store: async fetch, registered fetch copy,
// runtime load port, and async restore of the default program on reset.
module program_rom
  import program_rom_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
) (
  input  logic           clk,
  input  logic           rst_n,
  program_rom_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem;

  assign bus.prog = mem[bus.addr];

  // prog_q samples the pre-edge array, so a same-address write is read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem          <= DEFAULT_IMAGE;
      bus.prog_q   <= '0;
      bus.modified <= 1'b0;
    end else begin
      bus.prog_q <= mem[bus.addr];
      if (bus.wr_en) begin
        mem[bus.wr_addr] <= bus.wr_data;
        bus.modified     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_rom.sv
// Directed bench for program_rom: a bench-side ROM model plus a queue of
// expected prog_q values pushed at drive time and popped after each edge.
module tb_program_rom;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst_n;

  always #5 clk = clk_run ? ~clk : 1'b0;

  program_rom_if rom_if ();

  program_rom dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rom_if)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] model [16];
  logic [7:0] exp_q [$];
  logic       mod_exp;
  logic [3:0] cur_addr;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    model[0]  = 8'h10;
    model[1]  = 8'h21;
    model[2]  = 8'h40;
    model[3]  = 8'h51;
    model[15] = 8'hF0;
    mod_exp   = 1'b0;
  endtask

  // Called just after an edge: drive one cycle's inputs and predict its outcome.
  task automatic drive(input logic [3:0] a, input logic we, input logic [3:0] wa, input logic [7:0] wd);
    rom_if.addr    = a;
    rom_if.wr_en   = we;
    rom_if.wr_addr = wa;
    rom_if.wr_data = wd;
    cur_addr       = a;
    #1;
    check("prog_pre_edge", rom_if.prog, model[a]);
    exp_q.push_back(model[a]);
    if (we) begin
      model[wa] = wd;
      mod_exp   = 1'b1;
    end
  endtask

  task automatic cyc();
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_underflow: observed empty queue expected an entry");
    end else begin
      e = exp_q.pop_front();
      check("prog_q", rom_if.prog_q, e);
    end
    check("prog_post_edge", rom_if.prog, model[cur_addr]);
    check("modified", {7'd0, rom_if.modified}, {7'd0, mod_exp});
  endtask

  task automatic peek(input string tag, input logic [3:0] a, input logic [7:0] exp);
    rom_if.addr = a;
    #1;
    check(tag, rom_if.prog, exp);
  endtask

  initial begin
    rom_if.addr    = '0;
    rom_if.wr_en   = 1'b0;
    rom_if.wr_addr = '0;
    rom_if.wr_data = '0;
    cur_addr       = '0;
    reset_model();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #4;

    // Default image visible during reset, no clock.
    check("reset_prog0", rom_if.prog, 8'h10);
    check("reset_prog_q", rom_if.prog_q, 8'h00);
    check("reset_modified", {7'd0, rom_if.modified}, 8'h00);
    rst_n = 1'b1;
    #3;

    // Combinational fetch with the clock stopped.
    peek("async_a3", 4'd3, 8'h51);
    peek("async_a0", 4'd0, 8'h10);
    peek("async_a4", 4'd4, 8'h00);
    peek("async_a2", 4'd2, 8'h21 ^ 8'h61);  // OUT = 8'h40
    peek("async_a1", 4'd1, 8'h21);

    // First fetch latency: prog_q still zero before the first edge.
    check("prog_q_before_edge", rom_if.prog_q, 8'h00);
    clk_run = 1'b1;
    drive(4'd1, 1'b0, 4'd0, 8'h00);
    cyc();

    // Read-during-write at addr 4.
    drive(4'd4, 1'b1, 4'd4, 8'h3A);
    cyc();
    drive(4'd4, 1'b0, 4'd0, 8'h00);
    cyc();

    // Disabled writes leave the array and modified alone.
    for (int k = 0; k < 3; k++) begin
      drive(4'd5, 1'b0, 4'd5, 8'hFF);
      cyc();
    end

    // Overwrite 0 and 15, then pulse reset between edges.
    drive(4'd0, 1'b1, 4'd0, 8'h77);
    cyc();
    drive(4'd15, 1'b1, 4'd15, 8'h88);
    cyc();
    drive(4'd0, 1'b0, 4'd0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    check("rst_prog_q", rom_if.prog_q, 8'h00);
    check("rst_modified", {7'd0, rom_if.modified}, 8'h00);
    check("rst_prog0", rom_if.prog, 8'h10);
    peek("rst_prog15", 4'd15, 8'hF0);
    exp_q.delete();
    reset_model();

    // Writes held off while reset spans an edge.
    rom_if.wr_en   = 1'b1;
    rom_if.wr_addr = 4'd2;
    rom_if.wr_data = 8'hEE;
    @(posedge clk);
    #1;
    peek("rst_write_ignored", 4'd2, 8'h40);
    check("rst_modified_held", {7'd0, rom_if.modified}, 8'h00);
    rom_if.wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();

    // Fill with addr*0x11, then read back through both paths.
    for (int i = 0; i < 16; i++) begin
      drive(4'(i), 1'b1, 4'(i), 8'(i * 8'h11));
      cyc();
    end
    for (int i = 0; i < 16; i++) begin
      drive(4'(i), 1'b0, 4'd0, 8'h00);
      check("fill_readback", rom_if.prog, 8'(i * 8'h11));
      cyc();
    end

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
    end

    clk_run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
